// File: rtl/dmem_arbiter_if.sv
// Requester-side and memory-side signals of the two-port data-memory arbiter.
// The arbiter takes the slave view and the requesters/memory take the master view.
interface dmem_arbiter_if #(
    parameter int DBITS = 32,
    parameter int ABITS = 32
) ();
    logic             req0, req1;
    logic             we0, we1;
    logic             lock0, lock1;
    logic [ABITS-1:0] addr0, addr1;
    logic [DBITS-1:0] wdata0, wdata1;
    logic             gnt0, gnt1;
    logic             rvalid0, rvalid1;
    logic [DBITS-1:0] rdata;
    logic             stall0;
    logic             mem_en, mem_we;
    logic [ABITS-1:0] mem_addr;
    logic [DBITS-1:0] mem_wdata;
    logic [DBITS-1:0] mem_rdata;

    modport slave (
        input  req0, req1, we0, we1, lock0, lock1, addr0, addr1, wdata0, wdata1, mem_rdata,
        output gnt0, gnt1, rvalid0, rvalid1, rdata, stall0, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req0, req1, we0, we1, lock0, lock1, addr0, addr1, wdata0, wdata1, mem_rdata,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata, stall0, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: 0-cycle grant, rvalid one cycle after a read grant, capped locked bursts;
// the loser simply sees no grant (port 0 gets stall0). Define DMEM_ARB_RR_EN for round-robin idle ties.
module dmem_arbiter #(
    parameter int DBITS     = 32,
    parameter int ABITS     = 32,
    parameter int MAX_BURST = 8
) (
    input  logic            clk,
    input  logic            reset,
    dmem_arbiter_if.slave   bus
);
    localparam int CW = $clog2(MAX_BURST) + 1;
    localparam logic [CW-1:0] CAP = CW'(MAX_BURST - 1);

    typedef enum logic [1:0] {IDLE, HOLD0, HOLD1} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          last_q, last_d;
    logic          force_q, force_d;
    logic          rvalid0_q, rvalid0_d;
    logic          rvalid1_q, rvalid1_d;
    logic          g0, g1;
    logic          pick0;
    logic          arb_free;

    // force_q marks that a burst just ended with a grant, so the other port wins the next tie
`ifdef DMEM_ARB_RR_EN
    assign pick0 = last_q;
`else
    assign pick0 = force_q ? last_q : 1'b1;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        force_d  = force_q;
        g0       = 1'b0;
        g1       = 1'b0;
        arb_free = 1'b0;

        case (state_q)
            HOLD0: begin
                if (bus.req0) begin
                    g0     = 1'b1;
                    last_d = 1'b0;
                    if (bus.lock0 && (cnt_q < CAP)) begin
                        cnt_d = cnt_q + 1'b1;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        force_d = 1'b1;
                    end
                end else begin
                    arb_free = 1'b1;
                end
            end
            HOLD1: begin
                if (bus.req1) begin
                    g1     = 1'b1;
                    last_d = 1'b1;
                    if (bus.lock1 && (cnt_q < CAP)) begin
                        cnt_d = cnt_q + 1'b1;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        force_d = 1'b1;
                    end
                end else begin
                    arb_free = 1'b1;
                end
            end
            default: arb_free = 1'b1;
        endcase

        // An owner that stops requesting frees the port within the same cycle
        if (arb_free) begin
            state_d = IDLE;
            cnt_d   = '0;
            if (bus.req0 && (!bus.req1 || pick0)) begin
                g0      = 1'b1;
                last_d  = 1'b0;
                force_d = 1'b0;
                if (bus.lock0) begin
                    state_d = HOLD0;
                    cnt_d   = CW'(1);
                end
            end else if (bus.req1) begin
                g1      = 1'b1;
                last_d  = 1'b1;
                force_d = 1'b0;
                if (bus.lock1) begin
                    state_d = HOLD1;
                    cnt_d   = CW'(1);
                end
            end
        end

        rvalid0_d = g0 & ~bus.we0;
        rvalid1_d = g1 & ~bus.we1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            last_q    <= 1'b1;
            force_q   <= 1'b0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            force_q   <= force_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
        end
    end

    assign bus.gnt0    = g0 & ~reset;
    assign bus.gnt1    = g1 & ~reset;
    assign bus.stall0  = bus.req0 & ~bus.gnt0;
    assign bus.rvalid0 = rvalid0_q & ~reset;
    assign bus.rvalid1 = rvalid1_q & ~reset;
    assign bus.rdata   = bus.mem_rdata;

    assign bus.mem_en    = bus.gnt0 | bus.gnt1;
    assign bus.mem_we    = bus.gnt0 ? bus.we0    : (bus.gnt1 ? bus.we1    : 1'b0);
    assign bus.mem_addr  = bus.gnt0 ? bus.addr0  : (bus.gnt1 ? bus.addr1  : '0);
    assign bus.mem_wdata = bus.gnt0 ? bus.wdata0 : (bus.gnt1 ? bus.wdata1 : '0);
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small word memory behind the arbiter;
// per-cycle and read-data expectations are queued by the stimulus and retired by a negedge monitor.
module tb_dmem_arbiter;
    logic clk;
    logic reset;

    dmem_arbiter_if #(.DBITS(32), .ABITS(32)) bus ();

    dmem_arbiter #(.DBITS(32), .ABITS(32), .MAX_BURST(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem [0:255];
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
            else            bus.mem_rdata <= mem[bus.mem_addr[9:2]];
        end
    end

    typedef struct {
        logic        rst;
        logic        g0, g1, st0, en, we;
        logic [31:0] addr, wdata;
    } cyc_t;

    typedef struct {
        logic        port;
        logic [31:0] data;
    } rd_t;

    cyc_t cq[$];
    rd_t  rq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc_no = 0;

    always @(negedge clk) begin
        cyc_t e;
        rd_t  r;
        if (cq.size() > 0) begin
            e = cq.pop_front();
            cyc_no++;
            checks++;
            if ({bus.gnt0, bus.gnt1, bus.stall0, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata} !==
                {e.g0, e.g1, e.st0, e.en, e.we, e.addr, e.wdata}) begin
                errors++;
                $display("FAIL cyc%0d ctrl: got g0=%b g1=%b st0=%b en=%b we=%b a=%h d=%h want g0=%b g1=%b st0=%b en=%b we=%b a=%h d=%h",
                         cyc_no, bus.gnt0, bus.gnt1, bus.stall0, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata,
                         e.g0, e.g1, e.st0, e.en, e.we, e.addr, e.wdata);
            end
            if (e.rst) begin
                checks++;
                if ({bus.rvalid0, bus.rvalid1} !== 2'b00) begin
                    errors++;
                    $display("FAIL cyc%0d rst_rvalid: got %b%b want 00", cyc_no, bus.rvalid0, bus.rvalid1);
                end
            end
        end
        if (bus.rvalid0 === 1'b1 || bus.rvalid1 === 1'b1) begin
            checks++;
            if (rq.size() == 0) begin
                errors++;
                $display("FAIL cyc%0d unexpected_rvalid: got rv0=%b rv1=%b want none", cyc_no, bus.rvalid0, bus.rvalid1);
            end else begin
                r = rq.pop_front();
                if ({bus.rvalid0, bus.rvalid1, bus.rdata} !== {~r.port, r.port, r.data}) begin
                    errors++;
                    $display("FAIL cyc%0d rdata: got rv0=%b rv1=%b d=%h want rv0=%b rv1=%b d=%h", cyc_no,
                             bus.rvalid0, bus.rvalid1, bus.rdata, ~r.port, r.port, r.data);
                end
            end
        end
    end

    task automatic set0(input logic r, input logic w, input logic l, input logic [31:0] a, input logic [31:0] d);
        bus.req0 = r; bus.we0 = w; bus.lock0 = l; bus.addr0 = a; bus.wdata0 = d;
    endtask

    task automatic set1(input logic r, input logic w, input logic l, input logic [31:0] a, input logic [31:0] d);
        bus.req1 = r; bus.we1 = w; bus.lock1 = l; bus.addr1 = a; bus.wdata1 = d;
    endtask

    // eg0/eg1 are the hand-derived grants; erd is the word the granted read must return
    task automatic tick(input logic eg0, input logic eg1, input logic [31:0] erd, input logic rd_exp);
        cyc_t e;
        rd_t  r;
        e.rst   = 1'b0;
        e.g0    = eg0;
        e.g1    = eg1;
        e.st0   = bus.req0 & ~eg0;
        e.en    = eg0 | eg1;
        e.we    = eg0 ? bus.we0    : (eg1 ? bus.we1    : 1'b0);
        e.addr  = eg0 ? bus.addr0  : (eg1 ? bus.addr1  : 32'h0);
        e.wdata = eg0 ? bus.wdata0 : (eg1 ? bus.wdata1 : 32'h0);
        cq.push_back(e);
        if (rd_exp && ((eg0 && !bus.we0) || (eg1 && !bus.we1))) begin
            r.port = eg1;
            r.data = erd;
            rq.push_back(r);
        end
        @(posedge clk); #1;
    endtask

    task automatic rst_tick();
        cyc_t e;
        reset   = 1'b1;
        e.rst   = 1'b1;
        e.g0    = 1'b0;
        e.g1    = 1'b0;
        e.st0   = bus.req0;
        e.en    = 1'b0;
        e.we    = 1'b0;
        e.addr  = 32'h0;
        e.wdata = 32'h0;
        cq.push_back(e);
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[32'h100 >> 2] = 32'hDEADBEEF;
        mem[32'h104 >> 2] = 32'hCAFEF00D;
        mem[32'h300 >> 2] = 32'h12345678;
        bus.mem_rdata = 32'h0;
        reset = 1'b1;
        set0(1, 0, 0, 32'h100, 0);
        set1(0, 0, 0, 32'h0, 0);
        @(posedge clk); #1;

        rst_tick();
        rst_tick();

        // lone port 0 read
        set0(1, 0, 0, 32'h100, 0);
        tick(1, 0, 32'hDEADBEEF, 1);
        set0(0, 0, 0, 0, 0);
        tick(0, 0, 0, 0);

        // unlocked contention, four cycles
        for (int i = 0; i < 4; i++) begin
            set0(1, 1, 0, 32'h40, 32'hA0 + i);
            set1(1, 1, 0, 32'h80, 32'hB0 + i);
`ifdef DMEM_ARB_RR_EN
            tick(i[0], ~i[0], 0, 0);
`else
            tick(1, 0, 0, 0);
`endif
        end
        set0(0, 0, 0, 0, 0); set1(0, 0, 0, 0, 0);
        tick(0, 0, 0, 0);

        // short port 0 burst released by lock0=0 hands the next tie to port 1
        set0(1, 1, 1, 32'h44, 32'h1);
        tick(1, 0, 0, 0);
        set0(1, 1, 0, 32'h48, 32'h2);
        tick(1, 0, 0, 0);

        // capped port 1 write burst against a continuously requesting port 0
        set0(1, 0, 0, 32'h100, 0);
        for (int i = 0; i < 8; i++) begin
            set1(1, 1, 1, 32'h200 + 4 * i, 32'h1000 + i);
            tick(0, 1, 0, 0);
        end
        set1(1, 1, 1, 32'h220, 32'h1008);
        tick(1, 0, 32'hDEADBEEF, 1);
        set0(0, 0, 0, 0, 0);
        set1(1, 1, 0, 32'h220, 32'h1008);
        tick(0, 1, 0, 0);

        // port 1 drops lock after three writes
        set0(0, 0, 0, 0, 0);
        set1(1, 1, 1, 32'h240, 32'h2000);
        tick(0, 1, 0, 0);
        set0(1, 0, 0, 32'h100, 0);
        set1(1, 1, 1, 32'h244, 32'h2001);
        tick(0, 1, 0, 0);
        set1(1, 1, 0, 32'h248, 32'h2002);
        tick(0, 1, 0, 0);
        set1(1, 1, 1, 32'h24C, 32'h2003);
        tick(1, 0, 32'hDEADBEEF, 1);

        // HOLD1 owner goes quiet while port 0 waits
        set0(0, 0, 0, 0, 0);
        set1(1, 0, 1, 32'h300, 0);
        tick(0, 1, 32'h12345678, 1);
        set0(1, 0, 0, 32'h104, 0);
        set1(0, 0, 0, 0, 0);
        tick(1, 0, 32'hCAFEF00D, 1);
        set0(1, 0, 0, 32'h204, 0);
        tick(1, 0, 32'h00001001, 1);

        // reset with a locked port 1 read in flight
        set0(0, 0, 0, 0, 0);
        set1(1, 0, 1, 32'h300, 0);
        tick(0, 1, 0, 0);
        set0(1, 0, 0, 32'h100, 0);
        rst_tick();
        tick(1, 0, 32'hDEADBEEF, 1);
        set0(0, 0, 0, 0, 0); set1(0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) tick(0, 0, 0, 0);

        @(negedge clk); #1;
        checks++;
        if (cq.size() != 0 || rq.size() != 0) begin
            errors++;
            $display("FAIL drain: got cyc_left=%0d rd_left=%0d want 0 0", cq.size(), rq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
